// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - push-button debounce signal bundle (glitch_cnt present with KEY_DEBOUNCE_GLITCH_EN)
interface key_debounce_if;
    logic       key_in;
    logic       key_out;
    logic       busy;
`ifdef KEY_DEBOUNCE_GLITCH_EN
    logic [7:0] glitch_cnt;

    modport master (output key_in, input key_out, input busy, input glitch_cnt);
    modport slave  (input key_in, output key_out, output busy, output glitch_cnt);
`else
    modport master (output key_in, input key_out, input busy);
    modport slave  (input key_in, output key_out, output busy);
`endif
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button debouncer with 2-flop sync and 4-state qualify FSM (optional KEY_DEBOUNCE_GLITCH_EN glitch counter)
module key_debounce #(
    parameter int CNT_MAX = 500000,
    parameter int CNT_W   = 20
) (
    input  logic              clk,
    input  logic              n_rst,
    key_debounce_if.slave     kif
);

    typedef enum logic [1:0] {
        ST_HI  = 2'd0,
        CHK_LO = 2'd1,
        ST_LO  = 2'd2,
        CHK_HI = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             key_out_q;
    logic             busy_q;

    // Two-flop synchronizer; idles high so reset never looks like a press
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= kif.key_in;
            sync2_q <= sync1_q;
        end
    end

    // FSM state and stability counter registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_HI;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a level is accepted after CNT_MAX consecutive stable samples;
    // any reversal during a check drops back to the stable state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_HI: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (sync2_q) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LO: begin
                cnt_d = '0;
                if (sync2_q) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!sync2_q) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_HI;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs registered from the state so key_out only moves once a level is accepted
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_out_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            key_out_q <= !((state_q == ST_LO) || (state_q == CHK_HI));
            busy_q    <= (state_q == CHK_LO) || (state_q == CHK_HI);
        end
    end

    assign kif.key_out = key_out_q;
    assign kif.busy    = busy_q;

`ifdef KEY_DEBOUNCE_GLITCH_EN
    logic       abort;
    logic [7:0] glitch_q;

    assign abort = ((state_q == CHK_LO) &&  sync2_q) ||
                   ((state_q == CHK_HI) && !sync2_q);

    // Saturating count of aborted qualifications
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            glitch_q <= 8'd0;
        end else if (abort && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign kif.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed testbench for key_debounce (CNT_MAX = 8)
module tb_key_debounce;

    localparam int CNT_MAX = 8;
    localparam int CNT_W   = 4;

    logic clk;
    logic n_rst;
    int   n_tests;
    int   n_fail;
    int   tick_cnt;
    logic prev_key;
    int   g_exp;

    key_debounce_if kif();

    key_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .kif   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream falling-edge tick detector model
    always @(negedge clk) begin
        if (n_rst && prev_key && !kif.key_out) tick_cnt <= tick_cnt + 1;
        prev_key <= kif.key_out;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        kif.key_in = 1'b1;
        step(3);
        n_tests++;
        if (kif.key_out !== 1'b1) begin n_fail++; $display("FAIL reset_key_out got %b want 1", kif.key_out); end
        n_tests++;
        if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", kif.busy); end
`ifdef KEY_DEBOUNCE_GLITCH_EN
        n_tests++;
        if (kif.glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_glitch got %0d want 0", kif.glitch_cnt); end
`endif
        g_exp = 0;
        n_rst = 1'b1;
        step(3);
        n_tests++;
        if (kif.key_out !== 1'b1) begin n_fail++; $display("FAIL post_reset_key_out got %b want 1", kif.key_out); end
    endtask

    task automatic test_clean_press();
        kif.key_in = 1'b0;
        step(3);
        n_tests++;
        if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL press_busy_e2 got %b want 0", kif.busy); end
        step(1);
        n_tests++;
        if (kif.busy !== 1'b1) begin n_fail++; $display("FAIL press_busy_e3 got %b want 1", kif.busy); end
        step(6);
        n_tests++;
        if (kif.key_out !== 1'b1) begin n_fail++; $display("FAIL press_key_e9 got %b want 1", kif.key_out); end
        step(1);
        n_tests++;
        if (kif.key_out !== 1'b0) begin n_fail++; $display("FAIL press_key_e10 got %b want 0", kif.key_out); end
        step(2);
        n_tests++;
        if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL press_busy_done got %b want 0", kif.busy); end
    endtask

    task automatic test_release(input int tick_snap);
        kif.key_in = 1'b1;
        step(10);
        n_tests++;
        if (kif.key_out !== 1'b0) begin n_fail++; $display("FAIL release_key_e9 got %b want 0", kif.key_out); end
        step(1);
        n_tests++;
        if (kif.key_out !== 1'b1) begin n_fail++; $display("FAIL release_key_e10 got %b want 1", kif.key_out); end
        step(4);
        n_tests++;
        if (tick_cnt - tick_snap !== 1) begin
            n_fail++; $display("FAIL release_ticks got %0d want 1", tick_cnt - tick_snap);
        end
    endtask

    task automatic test_glitch();
        logic stayed_high;
        stayed_high = 1'b1;
        kif.key_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (kif.key_out !== 1'b1) stayed_high = 1'b0;
        end
        kif.key_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (kif.key_out !== 1'b1) stayed_high = 1'b0;
        end
        g_exp = g_exp + 1;
        n_tests++;
        if (stayed_high !== 1'b1) begin n_fail++; $display("FAIL glitch_key_held got %b want 1", stayed_high); end
        n_tests++;
        if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", kif.busy); end
`ifdef KEY_DEBOUNCE_GLITCH_EN
        n_tests++;
        if (kif.glitch_cnt !== 8'(g_exp)) begin n_fail++; $display("FAIL glitch_cnt got %0d want %0d", kif.glitch_cnt, g_exp); end
`endif
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        pat = 8'b1100_1100;
        for (int i = 0; i < 8; i++) begin
            kif.key_in = pat[i];
            step(1);
        end
        kif.key_in = 1'b0;
        step(10);
        g_exp = g_exp + 2;
        n_tests++;
        if (kif.key_out !== 1'b1) begin n_fail++; $display("FAIL bounce_key_e9 got %b want 1", kif.key_out); end
        step(1);
        n_tests++;
        if (kif.key_out !== 1'b0) begin n_fail++; $display("FAIL bounce_key_e10 got %b want 0", kif.key_out); end
`ifdef KEY_DEBOUNCE_GLITCH_EN
        n_tests++;
        if (kif.glitch_cnt !== 8'(g_exp)) begin n_fail++; $display("FAIL bounce_glitch got %0d want %0d", kif.glitch_cnt, g_exp); end
`endif
        kif.key_in = 1'b1;
        step(12);
        n_tests++;
        if (kif.key_out !== 1'b1) begin n_fail++; $display("FAIL bounce_release got %b want 1", kif.key_out); end
    endtask

    task automatic test_reset_mid_check();
        kif.key_in = 1'b0;
        step(7);
        n_tests++;
        if (kif.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_pre got %b want 1", kif.busy); end
        n_rst = 1'b0;
        #1;
        n_tests++;
        if (kif.key_out !== 1'b1) begin n_fail++; $display("FAIL midrst_key got %b want 1", kif.key_out); end
        n_tests++;
        if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", kif.busy); end
        g_exp = 0;
        step(2);
        n_rst = 1'b1;
        step(10);
        n_tests++;
        if (kif.key_out !== 1'b1) begin n_fail++; $display("FAIL midrst_key_e9 got %b want 1", kif.key_out); end
        step(1);
        n_tests++;
        if (kif.key_out !== 1'b0) begin n_fail++; $display("FAIL midrst_key_e10 got %b want 0", kif.key_out); end
`ifdef KEY_DEBOUNCE_GLITCH_EN
        n_tests++;
        if (kif.glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_glitch got %0d want 0", kif.glitch_cnt); end
`endif
    endtask

    task automatic test_saturation();
        kif.key_in = 1'b1;
        step(12);
`ifdef KEY_DEBOUNCE_GLITCH_EN
        for (int i = 0; i < 300; i++) begin
            kif.key_in = 1'b0;
            step(1);
            kif.key_in = 1'b1;
            step(3);
        end
        step(4);
        n_tests++;
        if (kif.glitch_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_glitch got %0d want 255", kif.glitch_cnt); end
        kif.key_in = 1'b0;
        step(1);
        kif.key_in = 1'b1;
        step(6);
        n_tests++;
        if (kif.glitch_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", kif.glitch_cnt); end
`endif
        n_tests++;
        if (kif.key_out !== 1'b1) begin n_fail++; $display("FAIL sat_key got %b want 1", kif.key_out); end
    endtask

    initial begin
        int tick_snap;
        n_tests    = 0;
        n_fail     = 0;
        tick_cnt   = 0;
        prev_key   = 1'b1;
        g_exp      = 0;
        n_rst      = 1'b0;
        kif.key_in = 1'b1;
        #2;
        test_reset();
        tick_snap = tick_cnt;
        test_clean_press();
        test_release(tick_snap);
        test_glitch();
        test_bounce();
        test_reset_mid_check();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL provide parameter CNT_MAX, default 500000, meaning the number of consecutive stable synchronized cycles required to accept a new level (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
REQ-002 SHALL provide parameter CNT_W, default 20, meaning the stability counter width.
REQ-003 SHALL provide port clk, input, 1, the single system clock, with all logic on its rising edge.
REQ-004 SHALL provide port n_rst, input, 1, the reset, which is asynchronous and active-low.
REQ-005 SHALL provide port key_in, input, 1, the raw asynchronous push-button level, active-low, idle high.
REQ-006 SHALL provide port key_out, output, 1, the registered debounced level, idle high, which feeds the downstream falling-edge tick detector as its d input.
REQ-007 SHALL provide port busy, output, 1, high while a level change is being qualified (CHK_LO or CHK_HI).
REQ-008 SHALL provide port glitch_cnt, output, 8, the saturating count of rejected transitions; the port is present only when KEY_DEBOUNCE_GLITCH_EN is defined.

Function
REQ-009 SHALL pass key_in through a 2-flop synchronizer (sync1, then sync2), and only sync2 SHALL be used by the rest of the logic.
REQ-010 SHALL implement a 4-state FSM with states ST_HI, CHK_LO, ST_LO and CHK_HI.
REQ-011 In ST_HI, key_out = 1 and the counter is 0; sync2 = 0 SHALL go to CHK_LO with the counter set to 1.
REQ-012 In CHK_LO, sync2 = 0 SHALL increment the counter; when the counter equals CNT_MAX-1 and sync2 = 0, the FSM SHALL go to ST_LO, set key_out to 0 and clear the counter.
REQ-013 In CHK_LO, sync2 = 1 SHALL return to ST_HI, clear the counter and record one glitch.
REQ-014 ST_LO and CHK_HI SHALL mirror REQ-011 to REQ-013 with the polarities inverted.
REQ-015 Latency: a clean raw change set up before edge 0 SHALL update key_out exactly at edge CNT_MAX+2 (2 synchronizer edges plus CNT_MAX qualifying edges).
REQ-016 Any sync2 reversal before the counter reaches CNT_MAX-1 SHALL abort the qualification, leave key_out unchanged and restart the next qualification from count 1.
REQ-017 key_out SHALL be glitch-free: it changes at most once per qualified transition and never toggles in a CHK state.
REQ-018 busy SHALL be registered from the state: 1 in CHK_LO and CHK_HI, 0 in ST_HI and ST_LO.
REQ-019 The counter SHALL never exceed CNT_MAX-1 and SHALL never wrap.
REQ-020 An unreachable FSM encoding SHALL recover to ST_HI on the next edge, with the counter cleared.

Reset
REQ-021 While n_rst = 0, the block SHALL asynchronously force sync1 = 1, sync2 = 1, state = ST_HI, counter = 0, key_out = 1, busy = 0 and glitch_cnt = 0.
REQ-022 Reset asserted mid-qualification SHALL abort the qualification; after release, a held-low key_in SHALL re-qualify the full CNT_MAX+2 edges.
REQ-023 After reset release, the first sampled edge SHALL behave as a normal edge, with no spurious key_out change.

Configuration
REQ-024 With KEY_DEBOUNCE_GLITCH_EN defined, the block SHALL include the glitch_cnt port and counter: +1 per aborted CHK_LO or CHK_HI, saturating at 255.
REQ-025 Without KEY_DEBOUNCE_GLITCH_EN, the block SHALL omit the glitch_cnt port and its logic, with all other behaviour identical.

Verification (bench uses CNT_MAX = 8, 10 ns clock)
REQ-026 Clean press: key_in goes 1->0 before edge 0 and is held -> busy = 1 from edge 3 and key_out = 0 at edge 10, not before.
REQ-027 Glitch: key_in is low for 3 cycles, then high -> key_out stays 1, FSM returns to ST_HI, glitch_cnt = 1.
REQ-028 Bounce: key_in toggles at cycles 0, 2, 4 and 6, then is held low -> key_out = 0 exactly 10 edges after the last toggle, and glitch_cnt equals the number of aborted checks.
REQ-029 Release: from ST_LO, key_in goes 0->1 and is held -> key_out = 1 at edge 10, and the downstream tick detector fires exactly once on the earlier press only.
REQ-030 Reset mid-check: n_rst is pulsed low at count 5 with key_in held low -> key_out = 1 immediately, then key_out = 0 at 10 edges after release.
REQ-031 Saturation: 300 glitches are applied -> glitch_cnt = 255 and holds; with the macro undefined, the block builds without the glitch_cnt port.
